// File: rtl/rf_wb_arbiter_if.sv
// Bundles the writeback, MDU, decode and register-file write-port signals around rf_wb_arbiter.
// master = surrounding pipeline/MDU/register file, slave = the arbiter.
interface rf_wb_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        pipe_stall_o;

  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;

  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard_o;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic        fwd1_valid;
  logic        fwd2_valid;
  logic [31:0] fwd_data;

  modport master (
    output pipe_valid, pipe_addr, pipe_data,
    output mdu_valid, mdu_addr, mdu_data, mdu_issue, mdu_issue_rd,
    output dec_rs1, dec_rs2, dec_rd,
    input  pipe_stall_o, mdu_ready, hazard_o,
    input  wr_en, wr_addr, wr_data,
    input  fwd1_valid, fwd2_valid, fwd_data
  );

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data,
    input  mdu_valid, mdu_addr, mdu_data, mdu_issue, mdu_issue_rd,
    input  dec_rs1, dec_rs2, dec_rd,
    output pipe_stall_o, mdu_ready, hazard_o,
    output wr_en, wr_addr, wr_data,
    output fwd1_valid, fwd2_valid, fwd_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and the MDU, and tracks busy registers.
// Optional macro WB_FWD_EN: forward the registered write to decode instead of stalling on it.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  rf_wb_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] busy_q, busy_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic starve;
  logic mdu_hs;
  logic pipe_go;
  logic hazard;

  always_comb begin
    starve  = bus.mdu_valid && (wait_cnt_q == LIMIT);
    mdu_hs  = bus.mdu_valid && (!bus.pipe_valid || starve);
    pipe_go = bus.pipe_valid && !starve;

    wait_cnt_d = wait_cnt_q;
    if (!bus.mdu_valid || mdu_hs) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // x0 writes still complete the handshake but never reach the register file
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (mdu_hs) begin
      if (bus.mdu_addr != 5'd0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = bus.mdu_addr;
        wr_data_d = bus.mdu_data;
      end
    end else if (pipe_go) begin
      if (bus.pipe_addr != 5'd0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = bus.pipe_addr;
        wr_data_d = bus.pipe_data;
      end
    end

    // set is applied after clear so a same-cycle reissue keeps the register busy
    busy_d = busy_q;
    if (mdu_hs) begin
      busy_d[bus.mdu_addr] = 1'b0;
    end
    if (bus.mdu_issue && (bus.mdu_issue_rd != 5'd0)) begin
      busy_d[bus.mdu_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
      busy_q     <= 32'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // busy_q[0] is held at 0, so x0 operands never raise a hazard
  always_comb begin
    hazard = busy_q[bus.dec_rs1] | busy_q[bus.dec_rs2] | busy_q[bus.dec_rd];
`ifndef WB_FWD_EN
    hazard = hazard
           | (wr_en_q && (wr_addr_q == bus.dec_rs1) && (bus.dec_rs1 != 5'd0))
           | (wr_en_q && (wr_addr_q == bus.dec_rs2) && (bus.dec_rs2 != 5'd0));
`endif
  end

  assign bus.mdu_ready    = mdu_hs;
  assign bus.pipe_stall_o = starve && bus.pipe_valid;
  assign bus.hazard_o     = hazard;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.fwd_data     = wr_data_q;

`ifdef WB_FWD_EN
  assign bus.fwd1_valid = wr_en_q && (wr_addr_q == bus.dec_rs1) && (bus.dec_rs1 != 5'd0);
  assign bus.fwd2_valid = wr_en_q && (wr_addr_q == bus.dec_rs2) && (bus.dec_rs2 != 5'd0);
`else
  assign bus.fwd1_valid = 1'b0;
  assign bus.fwd2_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes go into a queue checked by a write-port monitor.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  wr_t  exp_q[$];

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic pv, input logic [4:0] pa, input logic [31:0] pd,
    input logic mv, input logic [4:0] ma, input logic [31:0] md,
    input logic iss, input logic [4:0] ird,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.pipe_valid   = pv;
    bus.pipe_addr    = pa;
    bus.pipe_data    = pd;
    bus.mdu_valid    = mv;
    bus.mdu_addr     = ma;
    bus.mdu_data     = md;
    bus.mdu_issue    = iss;
    bus.mdu_issue_rd = ird;
    bus.dec_rs1      = rs1;
    bus.dec_rs2      = rs2;
    bus.dec_rd       = rd;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every committed write must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL wr_unexpected: got addr=%0d data=%h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
          bad++;
          $display("[TB] FAIL wr_port: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.wr_addr, bus.wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_wr_en", 32'(bus.wr_en), 0);
    checkOutput("reset_wr_addr", 32'(bus.wr_addr), 0);
    checkOutput("reset_wr_data", bus.wr_data, 0);
    checkOutput("reset_hazard", 32'(bus.hazard_o), 0);
    checkOutput("reset_fwd1", 32'(bus.fwd1_valid), 0);
    #10;
    rst_n = 1'b1;
    tick();

    // pipeline-only write
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(5, 32'hDEADBEEF);
    #1;
    checkOutput("pipe_mdu_ready", 32'(bus.mdu_ready), 0);
    checkOutput("pipe_stall", 32'(bus.pipe_stall_o), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    #1;
    checkOutput("pipe_wr_en", 32'(bus.wr_en), 1);
`ifdef WB_FWD_EN
    checkOutput("pipe_fwd1", 32'(bus.fwd1_valid), 1);
    checkOutput("pipe_fwd_hazard", 32'(bus.hazard_o), 0);
`else
    checkOutput("pipe_fwd1", 32'(bus.fwd1_valid), 0);
    checkOutput("pipe_wr_hazard", 32'(bus.hazard_o), 1);
`endif
    tick();

    // collision: MDU waits 4 cycles while the pipeline keeps writing
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 12, 32'h1000 + 32'(i), 1, 7, 32'hCAFE0007, 0, 0, 0, 0, 0);
      expectWrite(12, 32'h1000 + 32'(i));
      #1;
      checkOutput("coll_wait_ready", 32'(bus.mdu_ready), 0);
      checkOutput("coll_wait_stall", 32'(bus.pipe_stall_o), 0);
      tick();
    end
    applyStimulus(1, 12, 32'h1004, 1, 7, 32'hCAFE0007, 0, 0, 0, 0, 0);
    expectWrite(7, 32'hCAFE0007);
    #1;
    checkOutput("coll_starve_ready", 32'(bus.mdu_ready), 1);
    checkOutput("coll_starve_stall", 32'(bus.pipe_stall_o), 1);
    tick();
    applyStimulus(1, 12, 32'h1004, 0, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(12, 32'h1004);
    #1;
    checkOutput("coll_mdu_wr_addr", 32'(bus.wr_addr), 7);
    checkOutput("coll_after_ready", 32'(bus.mdu_ready), 0);
    checkOutput("coll_after_stall", 32'(bus.pipe_stall_o), 0);
    tick();

    // busy scoreboard on rd=9
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    #1;
    checkOutput("sb_issue_hazard", 32'(bus.hazard_o), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    #1;
    checkOutput("sb_busy_hazard1", 32'(bus.hazard_o), 1);
    tick();
    #1;
    checkOutput("sb_busy_hazard2", 32'(bus.hazard_o), 1);
    tick();
    applyStimulus(0, 0, 0, 1, 9, 32'h00000099, 0, 0, 0, 9, 0);
    expectWrite(9, 32'h00000099);
    #1;
    checkOutput("sb_retire_ready", 32'(bus.mdu_ready), 1);
    checkOutput("sb_retire_hazard", 32'(bus.hazard_o), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    #1;
`ifdef WB_FWD_EN
    checkOutput("sb_clear_hazard", 32'(bus.hazard_o), 0);
    checkOutput("sb_clear_fwd2", 32'(bus.fwd2_valid), 1);
`else
    checkOutput("sb_clear_hazard", 32'(bus.hazard_o), 1);
    checkOutput("sb_clear_fwd2", 32'(bus.fwd2_valid), 0);
`endif
    tick();
    #1;
    checkOutput("sb_idle_hazard", 32'(bus.hazard_o), 0);
    tick();

    // same-cycle set and clear on rd=3
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 3, 32'h00000033, 1, 3, 0, 0, 0);
    expectWrite(3, 32'h00000033);
    #1;
    checkOutput("same_ready", 32'(bus.mdu_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    #1;
    checkOutput("same_busy_kept", 32'(bus.hazard_o), 1);
    tick();
    applyStimulus(0, 0, 0, 1, 3, 32'h00000034, 0, 0, 0, 0, 3);
    expectWrite(3, 32'h00000034);
    #1;
    checkOutput("same_retire_ready", 32'(bus.mdu_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    #1;
    checkOutput("same_cleared", 32'(bus.hazard_o), 0);
    tick();

    // x0 result and x0 issue
    applyStimulus(0, 0, 0, 1, 0, 32'h00000055, 1, 0, 0, 0, 0);
    #1;
    checkOutput("x0_ready", 32'(bus.mdu_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("x0_wr_en", 32'(bus.wr_en), 0);
    tick();

    // asynchronous reset mid-operation
    applyStimulus(1, 20, 32'h0000ABCD, 0, 0, 0, 1, 4, 0, 0, 0);
    expectWrite(20, 32'h0000ABCD);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    #1;
    checkOutput("rst_pre_hazard", 32'(bus.hazard_o), 1);
    checkOutput("rst_pre_wr_en", 32'(bus.wr_en), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_en", 32'(bus.wr_en), 0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 0);
    checkOutput("rst_wr_data", bus.wr_data, 0);
    checkOutput("rst_hazard", 32'(bus.hazard_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    #1;
    checkOutput("rst_busy_cleared", 32'(bus.hazard_o), 0);
    tick();

    // write to x6 then read it in decode
    applyStimulus(1, 6, 32'h00000066, 0, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(6, 32'h00000066);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0);
    #1;
`ifdef WB_FWD_EN
    checkOutput("fwd_rs1_valid", 32'(bus.fwd1_valid), 1);
    checkOutput("fwd_rs1_data", bus.fwd_data, 32'h00000066);
    checkOutput("fwd_rs1_hazard", 32'(bus.hazard_o), 0);
`else
    checkOutput("fwd_rs1_valid", 32'(bus.fwd1_valid), 0);
    checkOutput("fwd_rs1_hazard", 32'(bus.hazard_o), 1);
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
